column_feeder: RTL

- Transmit-side source for the convolution layers.
- Accepts a feature map as a row-major pixel stream with a valid/ready handshake, one pixel per beat (all channels in parallel), and buffers the whole frame.
- Once the frame is buffered, replays it column by column as full-height column vectors with a single-cycle valid strobe. This is the format and strobe the conv layer expects on its input_columns/valid_in interface.
- Sits between the image/feature-map source and the first (or any) conv layer.

---
 rtl/cnn_pkg.sv | 18 +
 rtl/frame_buffer.sv | 40 ++++
 rtl/column_feeder.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/cnn_pkg.sv
// Types and default sizes shared by the column feeder and the conv layers.
package cnn_pkg;

    localparam int unsigned CNN_DATA_WIDTH           = 16;
    localparam int unsigned CNN_INPUT_COL_SIZE       = 12;
    localparam int unsigned CNN_INPUT_CHANNEL_NUMBER = 4;

    typedef enum logic {
        FILL   = 1'b0,
        STREAM = 1'b1
    } feeder_state_t;

    // Counter width for a bound n, never less than one bit.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/frame_buffer.sv
// Whole-frame pixel store: pixel-wide write at (row, col), full-column combinational read.
module frame_buffer
    import cnn_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = CNN_DATA_WIDTH,
    parameter int unsigned ROWS       = CNN_INPUT_COL_SIZE,
    parameter int unsigned COLS       = 12,
    parameter int unsigned CHANNELS   = CNN_INPUT_CHANNEL_NUMBER,
    parameter int unsigned ROW_W      = clog2_min1(ROWS),
    parameter int unsigned COL_W      = clog2_min1(COLS)
) (
    input  logic                                         clk,
    input  logic                                         i_we,
    input  logic [ROW_W-1:0]                             i_wr_row,
    input  logic [COL_W-1:0]                             i_wr_col,
    input  logic [CHANNELS-1:0][DATA_WIDTH-1:0]          i_wr_pix,
    input  logic [COL_W-1:0]                             i_rd_col,
    output logic [CHANNELS-1:0][ROWS-1:0][DATA_WIDTH-1:0] o_rd_column
);

    logic [DATA_WIDTH-1:0] r_mem [CHANNELS][ROWS][COLS];

    // Storage has no reset; every location is rewritten before it is read.
    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int ch = 0; ch < CHANNELS; ch++) begin
                r_mem[ch][i_wr_row][i_wr_col] <= i_wr_pix[ch];
            end
        end
    end

    always_comb begin
        for (int ch = 0; ch < CHANNELS; ch++) begin
            for (int r = 0; r < ROWS; r++) begin
                o_rd_column[ch][r] = r_mem[ch][r][i_rd_col];
            end
        end
    end

endmodule

// File: rtl/column_feeder.sv
// Buffers a row-major pixel frame, then replays it as full-height columns with a one-cycle strobe.
module column_feeder
    import cnn_pkg::*;
#(
    parameter int unsigned DATA_WIDTH           = CNN_DATA_WIDTH,
    parameter int unsigned INPUT_COL_SIZE       = CNN_INPUT_COL_SIZE,
    parameter int unsigned NUM_COLS             = 12,
    parameter int unsigned INPUT_CHANNEL_NUMBER = CNN_INPUT_CHANNEL_NUMBER,
    parameter int unsigned COL_GAP              = 0
) (
    input  logic                                                         clk,
    input  logic                                                         rst,
    input  logic [INPUT_CHANNEL_NUMBER-1:0][DATA_WIDTH-1:0]              pix_in,
    input  logic                                                         pix_valid,
    output logic                                                         pix_ready,
    output logic [INPUT_CHANNEL_NUMBER-1:0][INPUT_COL_SIZE-1:0][DATA_WIDTH-1:0] output_columns,
    output logic                                                         valid_out,
    output logic                                                         frame_done,
    output logic                                                         busy
);

    localparam int unsigned ROW_W = clog2_min1(INPUT_COL_SIZE);
    localparam int unsigned COL_W = clog2_min1(NUM_COLS);
    localparam int unsigned GAP_W = clog2_min1(COL_GAP + 1);

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(INPUT_COL_SIZE - 1);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(NUM_COLS - 1);
    localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'(COL_GAP);

    // Conv-layer kernel loading must finish before the first column can arrive.
    generate
        if (INPUT_COL_SIZE * NUM_COLS <= 3) begin : g_bad_frame
            $error("column_feeder: INPUT_COL_SIZE*NUM_COLS must exceed 3");
        end
        if (COL_GAP > 15) begin : g_bad_gap
            $error("column_feeder: COL_GAP must be within 0..15");
        end
    endgenerate

    feeder_state_t r_state, w_state_nx;
    logic [ROW_W-1:0] r_row, w_row_nx;
    logic [COL_W-1:0] r_col, w_col_nx;
    logic [GAP_W-1:0] r_gap, w_gap_nx;
    logic [INPUT_CHANNEL_NUMBER-1:0][INPUT_COL_SIZE-1:0][DATA_WIDTH-1:0] r_cols, w_cols_nx, w_column;
    logic r_valid, w_valid_nx;
    logic r_done, w_done_nx;
    logic w_we;
    logic w_adv;

    frame_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .ROWS       (INPUT_COL_SIZE),
        .COLS       (NUM_COLS),
        .CHANNELS   (INPUT_CHANNEL_NUMBER),
        .ROW_W      (ROW_W),
        .COL_W      (COL_W)
    ) u_frame_buffer (
        .clk         (clk),
        .i_we        (w_we),
        .i_wr_row    (r_row),
        .i_wr_col    (r_col),
        .i_wr_pix    (pix_in),
        .i_rd_col    (r_col),
        .o_rd_column (w_column)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= FILL;
            r_row   <= '0;
            r_col   <= '0;
            r_gap   <= '0;
            r_cols  <= '0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_row   <= w_row_nx;
            r_col   <= w_col_nx;
            r_gap   <= w_gap_nx;
            r_cols  <= w_cols_nx;
            r_valid <= w_valid_nx;
            r_done  <= w_done_nx;
        end
    end

    // STREAM emits when the gap counter is zero; the trailing gap after the last
    // column keeps the frame period at NUM_COLS*(COL_GAP+1) stream cycles.
    always_comb begin
        w_state_nx = r_state;
        w_row_nx   = r_row;
        w_col_nx   = r_col;
        w_gap_nx   = r_gap;
        w_cols_nx  = r_cols;
        w_valid_nx = 1'b0;
        w_done_nx  = 1'b0;
        w_we       = 1'b0;
        w_adv      = 1'b0;

        case (r_state)
            FILL: begin
                if (pix_valid) begin
                    w_we = 1'b1;
                    if (r_col == LAST_COL) begin
                        w_col_nx = '0;
                        if (r_row == LAST_ROW) begin
                            w_row_nx   = '0;
                            w_state_nx = STREAM;
                        end else begin
                            w_row_nx = r_row + ROW_W'(1);
                        end
                    end else begin
                        w_col_nx = r_col + COL_W'(1);
                    end
                end
            end
            STREAM: begin
                if (r_gap == '0) begin
                    w_cols_nx  = w_column;
                    w_valid_nx = 1'b1;
                    w_done_nx  = (r_col == LAST_COL);
                    if (COL_GAP == 0) begin
                        w_adv = 1'b1;
                    end else begin
                        w_gap_nx = GAP_W'(1);
                    end
                end else if (r_gap == LAST_GAP) begin
                    w_gap_nx = '0;
                    w_adv    = 1'b1;
                end else begin
                    w_gap_nx = r_gap + GAP_W'(1);
                end
            end
            default: w_state_nx = FILL;
        endcase

        if (w_adv) begin
            if (r_col == LAST_COL) begin
                w_col_nx   = '0;
                w_state_nx = FILL;
            end else begin
                w_col_nx = r_col + COL_W'(1);
            end
        end
    end

    assign pix_ready      = (r_state == FILL);
    assign busy           = (r_state == STREAM);
    assign output_columns = r_cols;
    assign valid_out      = r_valid;
    assign frame_done     = r_done;

endmodule
